// File: rtl/sg_list_writer_64_if.sv
// Element-source and SG-buffer-write signal bundle for sg_list_writer_64.
// The writer uses the slave modport; the element source and FIFO side use master.
interface sg_list_writer_64_if #(
  parameter int C_DATA_WIDTH = 64
);
  logic                    valid;
  logic                    rdy;
  logic [63:0]             addr;
  logic [31:0]             len;
  logic [C_DATA_WIDTH-1:0] buf_data;
  logic                    buf_data_wen;
  logic                    buf_data_full;

  modport master (
    output valid, addr, len, buf_data_full,
    input  rdy, buf_data, buf_data_wen
  );

  modport slave (
    input  valid, addr, len, buf_data_full,
    output rdy, buf_data, buf_data_wen
  );
endinterface

// File: rtl/sg_list_writer_64.sv
// Packs {64-bit address, 32-bit length} elements into two consecutive SG buffer
// words (address, then length) and counts fully written elements.
module sg_list_writer_64 #(
  parameter int C_DATA_WIDTH  = 64,
  parameter int C_COUNT_WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  sg_list_writer_64_if.slave       sg_if,
  input  logic                     clear_i,
  output logic [C_COUNT_WIDTH-1:0] count_o,
  output logic                     idle_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WR_ADDR = 2'd1,
    S_WR_LEN  = 2'd2
  } state_t;

  state_t                   state_q;
  logic [63:0]              addr_q;
  logic [31:0]              len_q;
  logic [C_COUNT_WIDTH-1:0] count_q;
  logic [C_COUNT_WIDTH-1:0] count_d;

  logic [C_DATA_WIDTH-1:0]  buf_data_s;
  logic                     buf_wen_s;
  logic                     rdy_s;
  logic                     len_wr_s;

  // Word mux and handshakes; RDY is gated by reset so it drops the instant reset asserts.
  always_comb begin
    buf_data_s = {32'd0, len_q};
    buf_wen_s  = 1'b0;
    rdy_s      = 1'b0;
    case (state_q)
      S_IDLE: begin
        rdy_s = rst_n_i;
      end
      S_WR_ADDR: begin
        buf_data_s = addr_q;
        buf_wen_s  = !sg_if.buf_data_full;
      end
      S_WR_LEN: begin
        buf_wen_s = !sg_if.buf_data_full;
        rdy_s     = rst_n_i & !sg_if.buf_data_full;
      end
      default: begin
        buf_wen_s = 1'b0;
        rdy_s     = 1'b0;
      end
    endcase
  end

  assign len_wr_s = (state_q == S_WR_LEN) && !sg_if.buf_data_full;

  // Completed-element counter: clear dominates, increment saturates at all-ones.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (len_wr_s && (count_q != {C_COUNT_WIDTH{1'b1}})) begin
      count_d = count_q + 1'b1;
    end else begin
      count_d = count_q;
    end
  end

  // Element FSM and captured element; the length-word edge doubles as the back-to-back accept edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      addr_q  <= 64'd0;
      len_q   <= 32'd0;
      count_q <= '0;
    end else begin
      count_q <= count_d;
      case (state_q)
        S_IDLE: begin
          if (sg_if.valid) begin
            addr_q  <= sg_if.addr;
            len_q   <= sg_if.len;
            state_q <= S_WR_ADDR;
          end
        end
        S_WR_ADDR: begin
          if (!sg_if.buf_data_full) begin
            state_q <= S_WR_LEN;
          end
        end
        S_WR_LEN: begin
          if (!sg_if.buf_data_full) begin
            if (sg_if.valid) begin
              addr_q  <= sg_if.addr;
              len_q   <= sg_if.len;
              state_q <= S_WR_ADDR;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign sg_if.buf_data     = buf_data_s;
  assign sg_if.buf_data_wen = buf_wen_s;
  assign sg_if.rdy          = rdy_s;
  assign count_o            = count_q;
  assign idle_o             = (state_q == S_IDLE);

endmodule

// File: tb/tb_sg_list_writer_64.sv
// Directed, table-driven bench for sg_list_writer_64 plus hand-written reset and
// saturation sequences (the latter on a second instance with a 2-bit counter).
module tb_sg_list_writer_64;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic [15:0] count;
  logic        idle;
  logic        clear2;
  logic [1:0]  count2;
  logic        idle2;

  sg_list_writer_64_if #(.C_DATA_WIDTH(64)) bus1 ();
  sg_list_writer_64_if #(.C_DATA_WIDTH(64)) bus2 ();

  sg_list_writer_64 #(.C_DATA_WIDTH(64), .C_COUNT_WIDTH(16)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .sg_if   (bus1.slave),
    .clear_i (clear),
    .count_o (count),
    .idle_o  (idle)
  );

  sg_list_writer_64 #(.C_DATA_WIDTH(64), .C_COUNT_WIDTH(2)) dut_sat (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .sg_if   (bus2.slave),
    .clear_i (clear2),
    .count_o (count2),
    .idle_o  (idle2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        valid;
    logic [63:0] addr;
    logic [31:0] len;
    logic        full;
    logic        clr;
    logic        e_rdy;
    logic        e_wen;
    logic [63:0] e_data;
    logic [15:0] e_cnt;
    logic        e_idle;
  } vec_t;

  vec_t vecs[$];
  int   n_pass;
  int   n_total;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [63:0] a, input logic [31:0] l,
                     input logic f, input logic c, input logic er, input logic ew,
                     input logic [63:0] ed, input logic [15:0] ec, input logic ei);
    vec_t t;
    t.valid = v; t.addr = a; t.len = l; t.full = f; t.clr = c;
    t.e_rdy = er; t.e_wen = ew; t.e_data = ed; t.e_cnt = ec; t.e_idle = ei;
    vecs.push_back(t);
  endtask

  task automatic chk_out(input string tag, input logic er, input logic ew,
                         input logic [63:0] ed, input logic [15:0] ec, input logic ei);
    chk({tag, ".rdy"},  {63'd0, bus1.rdy},          {63'd0, er});
    chk({tag, ".wen"},  {63'd0, bus1.buf_data_wen}, {63'd0, ew});
    chk({tag, ".data"}, bus1.buf_data,              ed);
    chk({tag, ".cnt"},  {48'd0, count},             {48'd0, ec});
    chk({tag, ".idle"}, {63'd0, idle},              {63'd0, ei});
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation ran past its time budget");
    $fatal(1);
  end

  localparam logic [63:0] A_S  = 64'h0000_0001_2345_6780;
  localparam logic [63:0] A0   = 64'hAAAA_0000_0000_0010;
  localparam logic [63:0] A1   = 64'h1111_2222_3333_4440;
  localparam logic [63:0] A2   = 64'hFFFF_FFFF_FFFF_FFF8;
  localparam logic [63:0] A_ST = 64'h0123_4567_89AB_CDE0;
  localparam logic [63:0] L400 = 64'h0000_0000_0000_0400;
  localparam logic [63:0] LFF  = 64'h0000_0000_FFFF_FFFF;

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    clear   = 1'b0;
    clear2  = 1'b0;
    bus1.valid = 1'b0; bus1.addr = 64'd0; bus1.len = 32'd0; bus1.buf_data_full = 1'b0;
    bus2.valid = 1'b0; bus2.addr = 64'd0; bus2.len = 32'd0; bus2.buf_data_full = 1'b0;

    // Single element, FULL=0
    add(1'b1, A_S, 32'd1024, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0, 16'd0, 1'b1);
    add(1'b0, 64'd0, 32'd0,  1'b0, 1'b0, 1'b0, 1'b1, A_S,   16'd0, 1'b0);
    add(1'b0, 64'd0, 32'd0,  1'b0, 1'b0, 1'b1, 1'b1, L400,  16'd0, 1'b0);
    add(1'b0, 64'd0, 32'd0,  1'b0, 1'b0, 1'b1, 1'b0, L400,  16'd1, 1'b1);
    // Three back-to-back elements, VALID held high
    add(1'b1, A0, 32'h10,         1'b0, 1'b0, 1'b1, 1'b0, L400,         16'd1, 1'b1);
    add(1'b1, A1, 32'h20,         1'b0, 1'b0, 1'b0, 1'b1, A0,           16'd1, 1'b0);
    add(1'b1, A1, 32'h20,         1'b0, 1'b0, 1'b1, 1'b1, 64'h10,       16'd1, 1'b0);
    add(1'b1, A2, 32'hFFFF_FFFF,  1'b0, 1'b0, 1'b0, 1'b1, A1,           16'd2, 1'b0);
    add(1'b1, A2, 32'hFFFF_FFFF,  1'b0, 1'b0, 1'b1, 1'b1, 64'h20,       16'd2, 1'b0);
    add(1'b0, 64'd0, 32'd0,       1'b0, 1'b0, 1'b0, 1'b1, A2,           16'd3, 1'b0);
    add(1'b0, 64'd0, 32'd0,       1'b0, 1'b0, 1'b1, 1'b1, LFF,          16'd3, 1'b0);
    add(1'b0, 64'd0, 32'd0,       1'b0, 1'b0, 1'b1, 1'b0, LFF,          16'd4, 1'b1);
    // FULL stall: 3 cycles on the address word, 2 on the length word
    add(1'b1, A_ST, 32'd7, 1'b0, 1'b0, 1'b1, 1'b0, LFF,   16'd4, 1'b1);
    add(1'b0, 64'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, A_ST, 16'd4, 1'b0);
    add(1'b0, 64'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, A_ST, 16'd4, 1'b0);
    add(1'b0, 64'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, A_ST, 16'd4, 1'b0);
    add(1'b0, 64'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, A_ST, 16'd4, 1'b0);
    add(1'b0, 64'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 64'd7, 16'd4, 1'b0);
    add(1'b0, 64'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 64'd7, 16'd4, 1'b0);
    add(1'b0, 64'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 64'd7, 16'd4, 1'b0);
    add(1'b0, 64'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 64'd7, 16'd5, 1'b1);
    // CLEAR on the same edge as the L1 write, then one more element
    add(1'b1, 64'h1000, 32'd1, 1'b0, 1'b0, 1'b1, 1'b0, 64'd7,    16'd5, 1'b1);
    add(1'b1, 64'h2000, 32'd2, 1'b0, 1'b0, 1'b0, 1'b1, 64'h1000, 16'd5, 1'b0);
    add(1'b1, 64'h2000, 32'd2, 1'b0, 1'b0, 1'b1, 1'b1, 64'd1,    16'd5, 1'b0);
    add(1'b0, 64'd0, 32'd0,    1'b0, 1'b0, 1'b0, 1'b1, 64'h2000, 16'd6, 1'b0);
    add(1'b0, 64'd0, 32'd0,    1'b0, 1'b1, 1'b1, 1'b1, 64'd2,    16'd6, 1'b0);
    add(1'b1, 64'h3000, 32'd3, 1'b0, 1'b0, 1'b1, 1'b0, 64'd2,    16'd0, 1'b1);
    add(1'b0, 64'd0, 32'd0,    1'b0, 1'b0, 1'b0, 1'b1, 64'h3000, 16'd0, 1'b0);
    add(1'b0, 64'd0, 32'd0,    1'b0, 1'b0, 1'b1, 1'b1, 64'd3,    16'd0, 1'b0);
    add(1'b0, 64'd0, 32'd0,    1'b0, 1'b0, 1'b1, 1'b0, 64'd3,    16'd1, 1'b1);

    // Reset state, then synchronous-release away from the edge
    #1;
    chk_out("reset", 1'b0, 1'b0, 64'd0, 16'd0, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("post_reset.rdy", {63'd0, bus1.rdy}, 64'd1);

    foreach (vecs[i]) begin
      @(negedge clk);
      bus1.valid = vecs[i].valid;
      bus1.addr  = vecs[i].addr;
      bus1.len   = vecs[i].len;
      bus1.buf_data_full = vecs[i].full;
      clear      = vecs[i].clr;
      #1;
      chk_out($sformatf("vec%0d", i), vecs[i].e_rdy, vecs[i].e_wen, vecs[i].e_data,
              vecs[i].e_cnt, vecs[i].e_idle);
    end
    @(negedge clk);
    bus1.valid = 1'b0;
    clear = 1'b0;

    // Reset pulled mid-element, right after the address word is written
    @(negedge clk);
    bus1.valid = 1'b1; bus1.addr = 64'h0000_00AB_CDEF_0000; bus1.len = 32'd9;
    @(negedge clk);
    bus1.valid = 1'b0;
    #1;
    chk("rst_mid.a_wen", {63'd0, bus1.buf_data_wen}, 64'd1);
    chk("rst_mid.a_data", bus1.buf_data, 64'h0000_00AB_CDEF_0000);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_out("rst_mid.async", 1'b0, 1'b0, 64'd0, 16'd0, 1'b1);
    @(negedge clk);
    #1;
    chk("rst_mid.no_len_wen", {63'd0, bus1.buf_data_wen}, 64'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    bus1.valid = 1'b1; bus1.addr = 64'h0000_0000_0000_5550; bus1.len = 32'd5;
    #1;
    chk_out("rst_new.idle", 1'b1, 1'b0, 64'd0, 16'd0, 1'b1);
    @(negedge clk);
    bus1.valid = 1'b0;
    #1;
    chk_out("rst_new.addr", 1'b0, 1'b1, 64'h5550, 16'd0, 1'b0);
    @(negedge clk);
    #1;
    chk_out("rst_new.len", 1'b1, 1'b1, 64'd5, 16'd0, 1'b0);
    @(negedge clk);
    #1;
    chk_out("rst_new.done", 1'b1, 1'b0, 64'd5, 16'd1, 1'b1);

    // 2-bit counter saturates at 3
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus2.valid = 1'b1; bus2.addr = 64'(i) << 4; bus2.len = 32'(i + 1);
      @(negedge clk);
      bus2.valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk($sformatf("sat.cnt%0d", i), {62'd0, count2}, (i < 3) ? 64'(i + 1) : 64'd3);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sg_list_writer_64.md
# sg_list_writer_64

Packs scatter gather elements (64-bit address, 32-bit length) into the 64-bit scatter gather buffer FIFO as two consecutive words: address first, then length. It is the producer-side counterpart of the 64-bit SG list reader and emits exactly the word order that reader expects. It sits between the element source (host-descriptor fetch / channel control) and the write port of the SG buffer FIFO. It also keeps a count of completely written elements.

## Interface

- C_DATA_WIDTH, 64, buffer word width; only 64 is supported.
- C_COUNT_WIDTH, 16, width of the completed-element counter.

- CLK  in  1  clock.
- RST_N  in  1  asynchronous, active-low reset.
- VALID  in  1  element on ADDR/LEN is valid.
- RDY  out  1  element accepted on any edge where VALID & RDY.
- ADDR  in  64  element address.
- LEN  in  32  element length in words.
- BUF_DATA  out  C_DATA_WIDTH  word to SG buffer FIFO.
- BUF_DATA_WEN  out  1  SG buffer write enable.
- BUF_DATA_FULL  in  1  SG buffer full.
- CLEAR  in  1  synchronous clear of COUNT.
- COUNT  out  C_COUNT_WIDTH  elements fully written (both words), saturating.
- IDLE  out  1  no element held; the writer is in S_IDLE.

## Operation

- Registers: rState, rAddr[63:0], rLen[31:0], rCount. All are cleared asynchronously by RST_N low (state = S_IDLE, data = 0).
- States:
  - S_IDLE: RDY=1. On VALID, capture ADDR/LEN into rAddr/rLen and go to S_WR_ADDR.
  - S_WR_ADDR: BUF_DATA = rAddr; BUF_DATA_WEN = !BUF_DATA_FULL. If !FULL, go to S_WR_LEN; otherwise hold.
  - S_WR_LEN: BUF_DATA = {32'd0, rLen}; BUF_DATA_WEN = !BUF_DATA_FULL; RDY = !BUF_DATA_FULL.
    - If !FULL and VALID: capture the new element and go to S_WR_ADDR (back-to-back).
    - If !FULL and !VALID: go to S_IDLE.
    - If FULL: hold.
- Control outputs:
  - BUF_DATA_WEN is never asserted while BUF_DATA_FULL=1. It is combinational from state and FULL.
  - BUF_DATA in S_IDLE = {32'd0, rLen}. The value is don't-care for the FIFO, but it must be deterministic.
  - RDY = 0 in S_WR_ADDR. RDY = 0 while RST_N is low.
  - IDLE = (rState == S_IDLE).
- COUNT:
  - Increments on each edge where the length word is written (S_WR_LEN & !FULL).
  - Saturates at all-ones and never wraps.
- CLEAR: sets COUNT to 0 on the next edge. If CLEAR and an increment occur on the same edge, CLEAR wins and COUNT = 0. CLEAR does not affect the element in flight.
- Reset mid-element: the partially written element is discarded. The SG FIFO and its reader must be reset in the same domain so that word alignment is preserved. This is a system-level requirement; the block does not detect the condition.
- Undefined state encodings recover to S_IDLE on the next edge.

## Timing

- Reset values: RDY=0 (while RST_N low), BUF_DATA_WEN=0, BUF_DATA=0, COUNT=0, IDLE=1. Once RST_N is high: RDY=1.
- Latency with FULL=0, element accepted at edge N:
  - Address word written at edge N+1.
  - Length word written at edge N+2.
  - COUNT reflects the element after edge N+2.
- Throughput: one element per 2 cycles sustained with VALID held high and FULL=0. There are no bubbles between elements.
- FULL stall: each asserted cycle of FULL adds one cycle to the current word. BUF_DATA is held stable during the stall, and no word is duplicated or skipped.
- RST_N assertion is asynchronous; deassertion is taken synchronously by the following edge. The bench deasserts it away from the clock edge.

## Test plan

- Single element ADDR=64'h0000_0001_2345_6780, LEN=32'd1024, FULL=0:
  - WEN high for 2 cycles.
  - BUF_DATA = 64'h0000_0001_2345_6780, then 64'h0000_0000_0000_0400.
  - COUNT 0→1; IDLE returns to 1.
- Three back-to-back elements with VALID held high:
  - Exactly 6 writes on consecutive cycles, in order A0, L0, A1, L1, A2, L2.
  - RDY low only in S_WR_ADDR; COUNT=3.
- FULL asserted for 3 cycles during S_WR_ADDR, then 2 cycles during S_WR_LEN:
  - WEN=0 and BUF_DATA stable throughout each stall.
  - Total element time = 2+5 = 7 cycles; COUNT increments once.
- C_COUNT_WIDTH=2, 5 elements: COUNT reads 1, 2, 3, 3, 3 (saturates, no wrap).
- CLEAR pulsed on the same edge as the L1 write: COUNT=0 afterwards. The next element brings COUNT to 1.
- RST_N pulled low after the A0 write:
  - Outputs immediately go to their reset values; no L0 write occurs.
  - After release, a new element writes its A then L normally, and COUNT=1.
